axil_sram_slave: RTL and testbench

AXI4-Lite slave that terminates the UART receive master's write stream and any read traffic into the embedded SRAM. It sits directly downstream of the UART AXI master, across the bus, and drives a single-port synchronous SRAM with fixed read latency. Write and read channels share the SRAM port under alternating-priority arbitration. Each accepted address produces exactly one response.

---
 rtl/axil_sram_slave.sv | 188 ++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_sram_slave.sv
// AXI4-Lite word-addressed slave onto a single-port synchronous SRAM, write/read sharing one port.
// Define AXIL_SRAM_RANGE_CHECK_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module axil_sram_slave #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 18,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned MEMORY_ADDR_WIDTH  = 18,
    parameter int unsigned MEMORY_DATA_WIDTH  = 16,
    parameter int unsigned SRAM_READ_LATENCY  = 2
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTB,
    input  logic                              S_AXI_WAVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [MEMORY_ADDR_WIDTH-1:0]      SRAM_address,
    output logic [MEMORY_DATA_WIDTH-1:0]      SRAM_write_data,
    output logic                              SRAM_we_n,
    output logic                              SRAM_ub_n,
    output logic                              SRAM_lb_n,
    input  logic [MEMORY_DATA_WIDTH-1:0]      SRAM_read_data
);

    localparam int unsigned CNT_W = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_READ_LATENCY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} r_state_e;

    r_state_e r_state_q, r_state_d;
    logic [CNT_W-1:0]              cnt_q;
    logic                          last_grant_q;
    logic                          aw_full_q, w_full_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, rd_addr_q;
    logic [MEMORY_DATA_WIDTH-1:0]  w_data_q;
    logic [1:0]                    w_strb_q;

    logic aw_hs_c, w_hs_c, ar_hs_c;
    logic aw_full_d_c, w_full_d_c;
    logic wr_req_c, rd_req_c, wr_go_c, rd_go_c;
    logic rd_capture_c, r_done_c, arready_d_c;
    logic wr_oob_c, rd_oob_c;
    logic unused_bits;

`ifdef AXIL_SRAM_RANGE_CHECK_EN
    assign wr_oob_c = (aw_addr_q >> MEMORY_ADDR_WIDTH) != '0;
    assign rd_oob_c = (rd_addr_q >> MEMORY_ADDR_WIDTH) != '0;
`else
    assign wr_oob_c = 1'b0;
    assign rd_oob_c = 1'b0;
`endif

    assign unused_bits = ^{S_AXI_WDATA, S_AXI_WSTB, aw_addr_q, rd_addr_q};

    // Handshakes and port arbitration; a write may not issue while a read owns the port.
    always_comb begin : arb
        aw_hs_c     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs_c      = S_AXI_WAVALID && S_AXI_WREADY;
        ar_hs_c     = S_AXI_ARVALID && S_AXI_ARREADY;
        wr_req_c    = aw_full_q && w_full_q && !S_AXI_BVALID && (r_state_q != R_WAIT);
        rd_req_c    = (r_state_q == R_REQ);
        wr_go_c     = wr_req_c && (!rd_req_c || (last_grant_q == GRANT_RD));
        rd_go_c     = rd_req_c && (!wr_req_c || (last_grant_q == GRANT_WR));
        aw_full_d_c = aw_hs_c || (aw_full_q && !wr_go_c);
        w_full_d_c  = w_hs_c || (w_full_q && !wr_go_c);
    end

    always_ff @(posedge S_AXI_ACLK) begin : r_state_reg
        if (!S_AXI_ARESETN) r_state_q <= R_IDLE;
        else                r_state_q <= r_state_d;
    end

    always_comb begin : r_next
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs_c)        r_state_d = R_REQ;
            R_REQ:   if (rd_go_c)        r_state_d = R_WAIT;
            R_WAIT:  if (cnt_q == '0)    r_state_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY)   r_state_d = R_IDLE;
            default:                     r_state_d = R_IDLE;
        endcase
    end

    always_comb begin : r_out
        rd_capture_c = (r_state_q == R_WAIT) && (cnt_q == '0);
        r_done_c     = (r_state_q == R_RESP) && S_AXI_RREADY;
        arready_d_c  = (r_state_d == R_IDLE);
    end

    // Write holding registers and B channel.
    always_ff @(posedge S_AXI_ACLK) begin : wr_path
        if (!S_AXI_ARESETN) begin
            aw_full_q     <= 1'b0;
            w_full_q      <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            last_grant_q  <= GRANT_RD;
        end else begin
            aw_full_q     <= aw_full_d_c;
            w_full_q      <= w_full_d_c;
            S_AXI_AWREADY <= !aw_full_d_c;
            S_AXI_WREADY  <= !w_full_d_c;
            if (aw_hs_c) aw_addr_q <= S_AXI_AWADDR;
            if (w_hs_c) begin
                w_data_q <= S_AXI_WDATA[MEMORY_DATA_WIDTH-1:0];
                w_strb_q <= S_AXI_WSTB[1:0];
            end
            if (wr_go_c) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_oob_c ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
            if (wr_go_c)      last_grant_q <= GRANT_WR;
            else if (rd_go_c) last_grant_q <= GRANT_RD;
        end
    end

    // SRAM port drive; we_n is a single-cycle pulse, address held through a read.
    always_ff @(posedge S_AXI_ACLK) begin : sram_drive
        if (!S_AXI_ARESETN) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            SRAM_ub_n       <= 1'b1;
            SRAM_lb_n       <= 1'b1;
        end else begin
            SRAM_we_n <= 1'b1;
            if (wr_go_c) begin
                SRAM_address    <= MEMORY_ADDR_WIDTH'(aw_addr_q);
                SRAM_write_data <= w_data_q;
                SRAM_we_n       <= wr_oob_c;
                SRAM_ub_n       <= !w_strb_q[1] || wr_oob_c;
                SRAM_lb_n       <= !w_strb_q[0] || wr_oob_c;
            end else if (rd_go_c) begin
                SRAM_address <= MEMORY_ADDR_WIDTH'(rd_addr_q);
                SRAM_ub_n    <= 1'b0;
                SRAM_lb_n    <= 1'b0;
            end
        end
    end

    // Read address latch, latency counter and R channel.
    always_ff @(posedge S_AXI_ACLK) begin : rd_path
        if (!S_AXI_ARESETN) begin
            rd_addr_q     <= '0;
            cnt_q         <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            S_AXI_ARREADY <= arready_d_c;
            if (ar_hs_c) rd_addr_q <= S_AXI_ARADDR;
            if (rd_go_c)                                 cnt_q <= CNT_LOAD;
            else if ((r_state_q == R_WAIT) && (cnt_q != '0)) cnt_q <= cnt_q - CNT_W'(1);
            if (rd_capture_c) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_oob_c ? '0 : C_S_AXI_DATA_WIDTH'(SRAM_read_data);
                S_AXI_RRESP  <= rd_oob_c ? RESP_SLVERR : RESP_OKAY;
            end else if (r_done_c) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Scoreboard bench for axil_sram_slave: directed stimulus pushes expectations, a negedge monitor checks them.
// Covers both builds of AXIL_SRAM_RANGE_CHECK_EN via a 20-bit AXI address with an 18-bit SRAM.
module tb_axil_sram_slave;

    logic        clk = 1'b0;
    logic        S_AXI_ARESETN;
    logic [19:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTB;
    logic        S_AXI_WAVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [19:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n, SRAM_ub_n, SRAM_lb_n;
    logic [15:0] SRAM_read_data;

    always #5 clk = ~clk;

    axil_sram_slave #(
        .C_S_AXI_ADDR_WIDTH(20), .C_S_AXI_DATA_WIDTH(32), .MEMORY_ADDR_WIDTH(18),
        .MEMORY_DATA_WIDTH(16), .SRAM_READ_LATENCY(2)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTB(S_AXI_WSTB), .S_AXI_WAVALID(S_AXI_WAVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .SRAM_ub_n(SRAM_ub_n), .SRAM_lb_n(SRAM_lb_n), .SRAM_read_data(SRAM_read_data)
    );

    // SRAM model: byte-enabled write, two-cycle read (address registered by DUT, one more stage here).
    bit   [15:0] mem [0:262143];
    logic [15:0] rd_pipe = 16'h0;
    assign SRAM_read_data = rd_pipe;
    always @(posedge clk) begin
        if (!SRAM_we_n) begin
            if (!SRAM_ub_n) mem[SRAM_address][15:8] <= SRAM_write_data[15:8];
            if (!SRAM_lb_n) mem[SRAM_address][7:0]  <= SRAM_write_data[7:0];
        end
        rd_pipe <= mem[SRAM_address];
    end

    typedef struct packed { logic [17:0] addr; logic [15:0] data; logic ub_n; logic lb_n; } wr_exp_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_exp_t;

    wr_exp_t    exp_wr[$];
    logic [1:0] exp_b[$];
    r_exp_t     exp_r[$];
    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_run++;
        n_fail++;
        $display("FAIL %s: unexpected response 0x%0h with no expectation queued", name, act);
    endtask

    // Monitor: checks every SRAM write pulse and every completed B/R handshake.
    always @(negedge clk) begin
        wr_exp_t w;
        r_exp_t  r;
        logic [1:0] b;
        if (S_AXI_ARESETN) begin
            if (!SRAM_we_n) begin
                if (exp_wr.size() == 0) unexpected("sram_write", 32'(SRAM_address));
                else begin
                    w = exp_wr.pop_front();
                    check("sram_addr", 32'(SRAM_address), 32'(w.addr));
                    check("sram_wdata", 32'(SRAM_write_data), 32'(w.data));
                    check("sram_be_n", 32'({SRAM_ub_n, SRAM_lb_n}), 32'({w.ub_n, w.lb_n}));
                end
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) unexpected("bresp", 32'(S_AXI_BRESP));
                else begin
                    b = exp_b.pop_front();
                    check("bresp", 32'(S_AXI_BRESP), 32'(b));
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) unexpected("rdata", S_AXI_RDATA);
                else begin
                    r = exp_r.pop_front();
                    check("rdata", S_AXI_RDATA, r.data);
                    check("rresp", 32'(S_AXI_RRESP), 32'(r.resp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present any of AW / W / AR and return just after the edge where all requested handshakes completed.
    task automatic issue(input bit do_aw, input bit do_w, input bit do_ar, input logic [19:0] wa,
                         input logic [15:0] wd, input logic [1:0] ws, input logic [19:0] ra);
        bit aw_pend, w_pend, ar_pend, aw_hs, w_hs, ar_hs;
        aw_pend = do_aw; w_pend = do_w; ar_pend = do_ar;
        if (do_aw) begin S_AXI_AWADDR = wa; S_AXI_AWVALID = 1'b1; end
        if (do_w) begin S_AXI_WDATA = {16'hDEAD, wd}; S_AXI_WSTB = {2'b11, ws}; S_AXI_WAVALID = 1'b1; end
        if (do_ar) begin S_AXI_ARADDR = ra; S_AXI_ARVALID = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            if (!(aw_pend || w_pend || ar_pend)) break;
            @(negedge clk);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WAVALID && S_AXI_WREADY;
            ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            if (aw_hs) begin aw_pend = 1'b0; S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_pend = 1'b0;  S_AXI_WAVALID = 1'b0; end
            if (ar_hs) begin ar_pend = 1'b0; S_AXI_ARVALID = 1'b0; end
        end
        if (aw_pend || w_pend || ar_pend) begin
            n_run++;
            n_fail++;
            $display("FAIL handshake_timeout: pending aw=%0b w=%0b ar=%0b, required none", aw_pend, w_pend, ar_pend);
        end
    endtask

    task automatic rvalid_after(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (S_AXI_RVALID) begin n = i; break; end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    localparam logic [17:0] T6_WA [2] = '{18'h00200, 18'h00201};
    localparam logic [15:0] T6_WD [2] = '{16'h1111, 16'h2222};
    localparam logic [17:0] T6_RA [2] = '{18'h00010, 18'h00200};
    localparam logic [15:0] T6_RD [2] = '{16'hBEEF, 16'h1111};

    initial begin
        int n;
        S_AXI_ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTB = '0; S_AXI_WAVALID = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_flags", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                                S_AXI_BRESP, S_AXI_RRESP, SRAM_we_n, SRAM_ub_n, SRAM_lb_n}), 32'b0000000000111);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_sram_addr", 32'(SRAM_address), 0);
        check("rst_sram_wdata", 32'(SRAM_write_data), 0);
        S_AXI_ARESETN = 1'b1;
        tick();
        check("ready_after_reset", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'b111);

        // T1: AW+W together, one-cycle write pulse
        exp_wr.push_back({18'h00010, 16'hBEEF, 1'b0, 1'b0});
        exp_b.push_back(2'b00);
        issue(1, 1, 0, 20'h00010, 16'hBEEF, 2'b11, '0);
        check("t1_awready_e0", 32'(S_AXI_AWREADY), 0);
        check("t1_we_n_e0", 32'(SRAM_we_n), 1);
        tick();
        check("t1_we_n_e1", 32'(SRAM_we_n), 0);
        check("t1_bvalid_e1", 32'(S_AXI_BVALID), 1);
        check("t1_ready_e1", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'b11);
        tick();
        check("t1_we_n_e2", 32'(SRAM_we_n), 1);

        // T2: W three cycles before AW, lower byte only
        issue(0, 1, 0, '0, 16'h1234, 2'b01, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_no_write_before_aw", 32'(SRAM_we_n), 1);
        end
        exp_wr.push_back({18'h00005, 16'h1234, 1'b1, 1'b0});
        exp_b.push_back(2'b00);
        issue(1, 0, 0, 20'h00005, '0, '0, '0);
        tick();
        check("t2_we_n", 32'(SRAM_we_n), 0);
        repeat (2) tick();
        exp_r.push_back({32'h00000034, 2'b00});
        issue(0, 0, 1, '0, '0, '0, 20'h00005);
        rvalid_after(n);
        check("t2_read_latency", 32'(n), 3);
        repeat (2) tick();

        // T3: top address, read latency and R hold with RREADY low
        exp_wr.push_back({18'h3FFFF, 16'hA5A5, 1'b0, 1'b0});
        exp_b.push_back(2'b00);
        issue(1, 1, 0, 20'h3FFFF, 16'hA5A5, 2'b11, '0);
        repeat (3) tick();
        S_AXI_RREADY = 1'b0;
        exp_r.push_back({32'h0000A5A5, 2'b00});
        issue(0, 0, 1, '0, '0, '0, 20'h3FFFF);
        tick();
        check("t3_sram_addr_e1", 32'(SRAM_address), 32'h3FFFF);
        check("t3_read_we_n", 32'(SRAM_we_n), 1);
        rvalid_after(n);
        check("t3_read_latency", 32'(n + 1), 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_r_hold", 32'({S_AXI_RVALID, S_AXI_RRESP}), 32'b100);
            check("t3_rdata_hold", S_AXI_RDATA, 32'h0000A5A5);
        end
        S_AXI_RREADY = 1'b1;
        repeat (2) tick();

        // T4: BREADY low, second write accepted but held until B clears
        S_AXI_BREADY = 1'b0;
        exp_wr.push_back({18'h00100, 16'h5555, 1'b0, 1'b0});
        exp_b.push_back(2'b00);
        exp_wr.push_back({18'h00101, 16'h6666, 1'b0, 1'b0});
        exp_b.push_back(2'b00);
        issue(1, 1, 0, 20'h00100, 16'h5555, 2'b11, '0);
        tick();
        check("t4_bvalid", 32'(S_AXI_BVALID), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_b_hold", 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'b100);
        end
        issue(1, 1, 0, 20'h00101, 16'h6666, 2'b11, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_b_hold2", 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'b100);
            check("t4_no_issue", 32'(SRAM_we_n), 1);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        check("t4_bvalid_cleared", 32'(S_AXI_BVALID), 0);
        tick();
        check("t4_second_issue", 32'({SRAM_we_n, S_AXI_BVALID}), 32'b01);
        repeat (2) tick();

        // T5: reset with a read response pending and a write about to issue
        S_AXI_RREADY = 1'b0;
        issue(0, 0, 1, '0, '0, '0, 20'h00010);
        repeat (4) tick();
        check("t5_rvalid_pending", 32'(S_AXI_RVALID), 1);
        issue(1, 1, 0, 20'h00300, 16'h9999, 2'b11, '0);
        S_AXI_ARESETN = 1'b0;
        tick();
        check("t5_reset_drop", 32'({SRAM_we_n, S_AXI_BVALID, S_AXI_RVALID}), 32'b100);
        tick();
        S_AXI_ARESETN = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick();

        // T6: simultaneous read and write requests, two rounds
        for (int k = 0; k < 2; k++) begin
            exp_wr.push_back({T6_WA[k], T6_WD[k], 1'b0, 1'b0});
            exp_b.push_back(2'b00);
            exp_r.push_back({16'h0000, T6_RD[k], 2'b00});
            issue(1, 1, 1, 20'(T6_WA[k]), T6_WD[k], 2'b11, 20'(T6_RA[k]));
            tick();
            check("t6_write_first", 32'({SRAM_we_n, SRAM_address}), 32'(T6_WA[k]));
            tick();
            check("t6_read_second", 32'({SRAM_we_n, SRAM_ub_n, SRAM_lb_n, SRAM_address}),
                  32'({3'b100, T6_RA[k]}));
            rvalid_after(n);
            check("t6_read_latency", 32'(n), 2);
            repeat (2) tick();
        end

        // T7: address above the SRAM range
`ifdef AXIL_SRAM_RANGE_CHECK_EN
        exp_b.push_back(2'b10);
        issue(1, 1, 0, 20'h40000, 16'h7777, 2'b11, '0);
        tick();
        check("t7_no_we_pulse", 32'(SRAM_we_n), 1);
        check("t7_bresp", 32'(S_AXI_BRESP), 32'b10);
        repeat (2) tick();
        exp_r.push_back({32'h00000000, 2'b10});
`else
        exp_wr.push_back({18'h00000, 16'h7777, 1'b0, 1'b0});
        exp_b.push_back(2'b00);
        issue(1, 1, 0, 20'h40000, 16'h7777, 2'b11, '0);
        tick();
        check("t7_alias_we", 32'({SRAM_we_n, SRAM_address}), 0);
        check("t7_bresp", 32'(S_AXI_BRESP), 0);
        repeat (2) tick();
        exp_r.push_back({32'h00007777, 2'b00});
`endif
        issue(0, 0, 1, '0, '0, '0, 20'h40000);
        rvalid_after(n);
        check("t7_read_latency", 32'(n), 3);
        repeat (5) tick();

        check("wr_queue_drained", 32'(exp_wr.size()), 0);
        check("b_queue_drained", 32'(exp_b.size()), 0);
        check("r_queue_drained", 32'(exp_r.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
